// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module  : isqrt_pkg
// Brief   : Shared state encoding, derived widths and parameter checks for the
//           handshaked integer square root unit.
// Revision: 1.0 - initial release
// ============================================================================
package isqrt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    // Root width is half the operand width.
    function automatic int calc_r_w(input int in_w);
        return in_w / 2;
    endfunction

    // Number of CALC cycles needed to resolve every root bit.
    function automatic int calc_iters(input int in_w, input int steps);
        return (in_w / 2) / steps;
    endfunction

    // Counter must hold the value ITERS itself.
    function automatic int calc_cnt_w(input int in_w, input int steps);
        return $clog2(calc_iters(in_w, steps) + 1);
    endfunction

    // Legal configurations: even operand of at least 4 bits, steps divide root width.
    function automatic bit params_ok(input int in_w, input int steps);
        return (in_w >= 4) && ((in_w % 2) == 0) && (steps >= 1) &&
               (steps <= in_w / 2) && (((in_w / 2) % steps) == 0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/isqrt_step.sv
`default_nettype none
// ============================================================================
// Module  : isqrt_step
// Brief   : One restoring square-root iteration. Brings in the next operand
//           bit pair, compares against the trial (root<<2)|1 and resolves one
//           root bit. Purely combinational so it can be chained per cycle.
// Revision: 1.0 - initial release
// ============================================================================
module isqrt_step
    import isqrt_pkg::*;
#(
    parameter int R_W = 16
) (
    input  logic [R_W+1:0] i_rem,
    input  logic [R_W-1:0] i_root,
    input  logic [1:0]     i_pair,
    output logic [R_W+1:0] o_rem,
    output logic [R_W-1:0] o_root
);

    logic [R_W+1:0] w_rem_sh;
    logic [R_W+1:0] w_trial;
    logic           w_ge;

    // The remainder never exceeds 2*root, so the two bits shifted out are zero.
    assign w_rem_sh = (i_rem << 2) | {{R_W{1'b0}}, i_pair};
    assign w_trial  = {i_root, 2'b01};
    assign w_ge     = (w_rem_sh >= w_trial);
    assign o_rem    = w_ge ? (w_rem_sh - w_trial) : w_rem_sh;
    assign o_root   = (i_root << 1) | {{(R_W-1){1'b0}}, w_ge};

endmodule
`default_nettype wire

// File: rtl/isqrt_pipe_ctl.sv
`default_nettype none
// ============================================================================
// Module  : isqrt_pipe_ctl
// Brief   : Handshaked multi-cycle integer square root. Produces floor root,
//           remainder (relative to floor root) and exact flag, resolving
//           STEPS_PER_CYCLE root bits per clock.
//           Optional macro ISQRT_ROUND_EN: round root to nearest, saturating
//           at all-ones (out_sat flags the saturation).
// Revision: 1.0 - initial release
// ============================================================================
module isqrt_pipe_ctl
    import isqrt_pkg::*;
#(
    parameter int IN_W            = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [IN_W-1:0]        in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [IN_W/2-1:0]      out_root,
    output logic [IN_W/2:0]        out_rem,
    output logic                   out_exact,
    output logic                   out_sat,
    output logic                   busy
);

    localparam int R_W   = calc_r_w(IN_W);
    localparam int ITERS = calc_iters(IN_W, STEPS_PER_CYCLE);
    localparam int CNT_W = calc_cnt_w(IN_W, STEPS_PER_CYCLE);

    if (!params_ok(IN_W, STEPS_PER_CYCLE)) begin : g_bad_params
        $error("isqrt_pipe_ctl: IN_W must be even and >= 4; STEPS_PER_CYCLE must divide IN_W/2");
    end

    state_t            r_state;
    state_t            w_state_nxt;
    logic [IN_W-1:0]   r_opnd;
    logic [R_W+1:0]    r_rem;
    logic [R_W-1:0]    r_root;
    logic [CNT_W-1:0]  r_cnt;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_accept;
    logic              w_done;
    logic [R_W-1:0]    w_root_out;
    logic              w_sat;

    // Iteration chain: element 0 is the registered state, last is next state.
    logic [R_W+1:0]    w_rem  [0:STEPS_PER_CYCLE];
    logic [R_W-1:0]    w_root [0:STEPS_PER_CYCLE];

    assign w_rem[0]  = r_rem;
    assign w_root[0] = r_root;

    for (genvar s = 0; s < STEPS_PER_CYCLE; s++) begin : g_step
        isqrt_step #(
            .R_W    (R_W)
        ) u_step (
            .i_rem  (w_rem[s]),
            .i_root (w_root[s]),
            .i_pair (r_opnd[IN_W-1-2*s -: 2]),
            .o_rem  (w_rem[s+1]),
            .o_root (w_root[s+1])
        );
    end

    assign w_accept = in_valid && w_in_ready;

    // State register; reset abandons any in-flight operand.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state and handshake decode; DONE can hand off straight into CALC.
    always_comb begin
        w_state_nxt = r_state;
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;
        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = CALC;
                end
            end
            CALC: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                w_in_ready  = out_ready;
                if (out_ready) begin
                    w_state_nxt = in_valid ? CALC : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Datapath: load on accept, otherwise advance STEPS_PER_CYCLE bits in CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_opnd <= '0;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= '0;
        end else if (w_accept) begin
            r_opnd <= in_data;
            r_rem  <= '0;
            r_root <= '0;
            r_cnt  <= CNT_W'(ITERS);
        end else if (r_state == CALC) begin
            r_opnd <= r_opnd << (2 * STEPS_PER_CYCLE);
            r_rem  <= w_rem[STEPS_PER_CYCLE];
            r_root <= w_root[STEPS_PER_CYCLE];
            r_cnt  <= r_cnt - CNT_W'(1);
        end
    end

`ifdef ISQRT_ROUND_EN
    logic w_rnd_up;
    // Round up when the remainder passes the midpoint between root^2 and (root+1)^2.
    assign w_rnd_up   = (r_rem[R_W:0] > {1'b0, r_root});
    assign w_sat      = w_rnd_up && (&r_root);
    assign w_root_out = w_sat ? r_root : (r_root + R_W'(w_rnd_up));
`else
    assign w_sat      = 1'b0;
    assign w_root_out = r_root;
`endif

    // Results are only presented in DONE; everywhere else they read as zero.
    assign w_done    = (r_state == DONE);
    assign in_ready  = w_in_ready;
    assign out_valid = w_out_valid;
    assign out_root  = w_done ? w_root_out : '0;
    assign out_rem   = w_done ? r_rem[R_W:0] : '0;
    assign out_exact = w_done && (r_rem == '0);
    assign out_sat   = w_done && w_sat;
    assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_isqrt_pipe_ctl.sv
`default_nettype none
// ============================================================================
// Module  : tb_isqrt_pipe_ctl
// Brief   : Scoreboard bench for isqrt_pipe_ctl. Instance A is 32-bit/1 step,
//           instance B is 16-bit/2 steps. Expected results come from an
//           independent multiply-based square root model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_isqrt_pipe_ctl;

`ifdef ISQRT_ROUND_EN
    localparam bit ROUND = 1'b1;
`else
    localparam bit ROUND = 1'b0;
`endif

    localparam int A_ITERS = 16;
    localparam int B_ITERS = 4;

    typedef struct {
        longint unsigned x;
        int              cyc;
    } txn_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;

    logic        a_in_valid = 1'b0;
    logic        a_in_ready;
    logic [31:0] a_in_data = '0;
    logic        a_out_valid;
    logic        a_out_ready = 1'b1;
    logic [15:0] a_out_root;
    logic [16:0] a_out_rem;
    logic        a_out_exact;
    logic        a_out_sat;
    logic        a_busy;

    logic        b_in_valid = 1'b0;
    logic        b_in_ready;
    logic [15:0] b_in_data = '0;
    logic        b_out_valid;
    logic        b_out_ready = 1'b1;
    logic [7:0]  b_out_root;
    logic [8:0]  b_out_rem;
    logic        b_out_exact;
    logic        b_out_sat;
    logic        b_busy;

    int   n_chk = 0;
    int   n_err = 0;
    int   cyc   = 0;
    txn_t qa[$];
    txn_t qb[$];
    bit   a_seen = 1'b0;
    bit   b_seen = 1'b0;

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    isqrt_pipe_ctl #(.IN_W(32), .STEPS_PER_CYCLE(1)) u_dut_a (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (a_in_valid),
        .in_ready  (a_in_ready),
        .in_data   (a_in_data),
        .out_valid (a_out_valid),
        .out_ready (a_out_ready),
        .out_root  (a_out_root),
        .out_rem   (a_out_rem),
        .out_exact (a_out_exact),
        .out_sat   (a_out_sat),
        .busy      (a_busy)
    );

    isqrt_pipe_ctl #(.IN_W(16), .STEPS_PER_CYCLE(2)) u_dut_b (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (b_in_valid),
        .in_ready  (b_in_ready),
        .in_data   (b_in_data),
        .out_valid (b_out_valid),
        .out_ready (b_out_ready),
        .out_root  (b_out_root),
        .out_rem   (b_out_rem),
        .out_exact (b_out_exact),
        .out_sat   (b_out_sat),
        .busy      (b_busy)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Floor square root by bitwise search with multiplication.
    function automatic longint unsigned fsqrt(input longint unsigned x);
        longint unsigned r = 0;
        longint unsigned t;
        for (int b = 31; b >= 0; b--) begin
            t = r | (64'd1 << b);
            if (t * t <= x) r = t;
        end
        return r;
    endfunction

    function automatic void model(input longint unsigned x, input int rw,
                                  output longint unsigned er, output longint unsigned erem,
                                  output bit es);
        longint unsigned fl;
        fl   = fsqrt(x);
        erem = x - fl * fl;
        er   = fl;
        es   = 1'b0;
        if (ROUND && (erem > fl)) begin
            if (fl == ((64'd1 << rw) - 1)) es = 1'b1;
            else                          er = fl + 1;
        end
    endfunction

    // Scoreboard for instance A: latency on first valid, values on handshake.
    always @(negedge clk) begin
        longint unsigned er, erem;
        bit es;
        txn_t t;
        if (rst) begin
            a_seen <= 1'b0;
        end else begin
            if (a_out_valid && !a_seen) begin
                if (qa.size() == 0) chk("a_unexpected_out", 64'(qa.size()), 64'd1);
                else                chk("a_latency", 64'(cyc - qa[0].cyc), 64'(A_ITERS + 1));
                a_seen <= 1'b1;
            end
            if (a_out_valid && a_out_ready) begin
                if (qa.size() == 0) begin
                    chk("a_unexpected_hs", 64'(qa.size()), 64'd1);
                end else begin
                    t = qa.pop_front();
                    model(t.x, 16, er, erem, es);
                    chk("a_root",  64'(a_out_root),  er);
                    chk("a_rem",   64'(a_out_rem),   erem);
                    chk("a_exact", 64'(a_out_exact), 64'(erem == 0));
                    chk("a_sat",   64'(a_out_sat),   64'(es));
                end
                a_seen <= 1'b0;
            end
        end
    end

    // Scoreboard for instance B.
    always @(negedge clk) begin
        longint unsigned er, erem;
        bit es;
        txn_t t;
        if (rst) begin
            b_seen <= 1'b0;
        end else begin
            if (b_out_valid && !b_seen) begin
                if (qb.size() == 0) chk("b_unexpected_out", 64'(qb.size()), 64'd1);
                else                chk("b_latency", 64'(cyc - qb[0].cyc), 64'(B_ITERS + 1));
                b_seen <= 1'b1;
            end
            if (b_out_valid && b_out_ready) begin
                if (qb.size() == 0) begin
                    chk("b_unexpected_hs", 64'(qb.size()), 64'd1);
                end else begin
                    t = qb.pop_front();
                    model(t.x, 8, er, erem, es);
                    chk("b_root",  64'(b_out_root),  er);
                    chk("b_rem",   64'(b_out_rem),   erem);
                    chk("b_exact", 64'(b_out_exact), 64'(erem == 0));
                    chk("b_sat",   64'(b_out_sat),   64'(es));
                end
                b_seen <= 1'b0;
            end
        end
    end

    task automatic send_a(input logic [31:0] x);
        int n = 0;
        @(posedge clk); #1;
        a_in_data  = x;
        a_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (a_in_ready) begin
                qa.push_back('{x: 64'(x), cyc: cyc});
                break;
            end
            n++;
            if (n > 200) begin
                chk("a_accept_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = $urandom;
    endtask

    task automatic send_b(input logic [15:0] x);
        int n = 0;
        @(posedge clk); #1;
        b_in_data  = x;
        b_in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (b_in_ready) begin
                qb.push_back('{x: 64'(x), cyc: cyc});
                break;
            end
            n++;
            if (n > 200) begin
                chk("b_accept_timeout", 64'(n), 64'd0);
                break;
            end
        end
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_data  = 16'($urandom);
    endtask

    task automatic drain(input bit which_b);
        int n = 0;
        while ((which_b ? qb.size() : qa.size()) != 0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        chk(which_b ? "b_drain" : "a_drain", 64'(which_b ? qb.size() : qa.size()), 64'd0);
    endtask

    initial begin
        logic [31:0] a_vec [10];
        logic [15:0] r_hold;
        logic [16:0] m_hold;
        int n;
        a_vec = '{32'd144, 32'd200, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd3,
                  32'd210, 32'd211, 32'hFFFE_0001, 32'd1_000_000};

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_in_ready",  64'(a_in_ready),  64'd1);
        chk("rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("rst_root",      64'(a_out_root),  64'd0);
        chk("rst_rem",       64'(a_out_rem),   64'd0);
        chk("rst_exact",     64'(a_out_exact), 64'd0);
        chk("rst_sat",       64'(a_out_sat),   64'd0);
        chk("rst_busy",      64'(a_busy),      64'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Directed operands, one at a time
        for (int i = 0; i < 10; i++) begin
            send_a(a_vec[i]);
            drain(1'b0);
        end

        // Backpressure in DONE, then same-cycle accept of the next operand
        a_out_ready = 1'b0;
        send_a(32'd625);
        n = 0;
        while (!a_out_valid && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("bp_valid_seen", 64'(a_out_valid), 64'd1);
        r_hold = a_out_root;
        m_hold = a_out_rem;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("bp_out_valid", 64'(a_out_valid), 64'd1);
            chk("bp_in_ready",  64'(a_in_ready),  64'd0);
            chk("bp_root_hold", 64'(a_out_root),  64'(r_hold));
            chk("bp_rem_hold",  64'(a_out_rem),   64'(m_hold));
        end
        @(posedge clk); #1;
        a_out_ready = 1'b1;
        a_in_data   = 32'd81;
        a_in_valid  = 1'b1;
        @(negedge clk);
        chk("b2b_in_ready", 64'(a_in_ready), 64'd1);
        if (a_in_ready) qa.push_back('{x: 64'd81, cyc: cyc});
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        drain(1'b0);

        // Reset in the middle of CALC
        send_a(32'd123_456_789);
        repeat (7) @(posedge clk);
        @(negedge clk);
        chk("mid_busy", 64'(a_busy), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1;
        qa.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_busy",      64'(a_busy),      64'd0);
        chk("mid_rst_out_valid", 64'(a_out_valid), 64'd0);
        chk("mid_rst_in_ready",  64'(a_in_ready),  64'd1);
        send_a(32'd50);
        drain(1'b0);

        // Second configuration: boundaries then random sweep
        send_b(16'hFFFF);
        drain(1'b1);
        send_b(16'd0);
        send_b(16'd1);
        for (int i = 0; i < 1000; i++) begin
            send_b(16'($urandom_range(0, 65535)));
        end
        drain(1'b1);

        repeat (3) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
